// File: rtl/maxplus_pkg.sv
// -----------------------------------------------------------------------------
// maxplus_pkg
//   Shared definitions for the max-plus cycle-mean engine.
//   - all_ones()  : EPS code (all-ones) for an arbitrary width, returned in
//                   MP_W bits; callers cast it down to their own width.
//   - acc_width() : internal power-element width, wide enough that the
//                   largest non-EPS value N*(2^DW-2) stays below EPS.
//   - state_t     : engine FSM states (DIV only used with the quotient build).
//   - mp_mul()    : tropical product (EPS-absorbing addition).
//   - mp_max()    : tropical sum (max with EPS acting as -infinity).
//   The arithmetic helpers work on MP_W-bit operands so one definition
//   serves every parameterisation; callers zero-extend in and truncate out.
// -----------------------------------------------------------------------------
package maxplus_pkg;

    localparam int MP_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [MP_W-1:0] all_ones(input int w);
        logic [MP_W-1:0] r;
        r = '0;
        for (int b = 0; b < MP_W; b++) begin
            if (b < w) r[b] = 1'b1;
        end
        return r;
    endfunction

    function automatic int acc_width(input int n, input int dw);
        return dw + $clog2(n) + 1;
    endfunction

    // Operands are bounded well below EPS, so the plain sum never wraps
    // into the EPS code for legal matrices.
    function automatic logic [MP_W-1:0] mp_mul(input logic [MP_W-1:0] a,
                                               input logic [MP_W-1:0] b,
                                               input logic [MP_W-1:0] eps);
        if (a == eps || b == eps) return eps;
        return a + b;
    endfunction

    function automatic logic [MP_W-1:0] mp_max(input logic [MP_W-1:0] a,
                                               input logic [MP_W-1:0] b,
                                               input logic [MP_W-1:0] eps);
        if (a == eps) return b;
        if (b == eps) return a;
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/maxplus_mac.sv
// -----------------------------------------------------------------------------
// maxplus_mac
//   Registered max-plus accumulate step, shared by every element of the
//   matrix product (one step per cycle).
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     en          : advance the accumulator this cycle
//     clear       : first term of a dot product (accumulator treated as EPS)
//     p_elem      : P[i][l]
//     a_elem      : A[l][j]
//     acc_next    : combinational result of this step (used directly by the
//                   caller on the last term, before it is registered)
// -----------------------------------------------------------------------------
module maxplus_mac
    import maxplus_pkg::*;
#(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clear,
    input  logic [W-1:0] p_elem,
    input  logic [W-1:0] a_elem,
    output logic [W-1:0] acc_next
);

    localparam logic [W-1:0] EPS = W'(all_ones(W));

    logic [W-1:0]    acc_q;
    logic [MP_W-1:0] prod;
    logic [MP_W-1:0] acc_in;

    assign prod     = mp_mul(MP_W'(p_elem), MP_W'(a_elem), MP_W'(EPS));
    assign acc_in   = clear ? MP_W'(EPS) : MP_W'(acc_q);
    assign acc_next = W'(mp_max(acc_in, prod, MP_W'(EPS)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= EPS;
        end else if (en) begin
            acc_q <= acc_next;
        end
    end

endmodule

// File: rtl/maxplus_cycle_mean.sv
// -----------------------------------------------------------------------------
// maxplus_cycle_mean
//   Computes A^1..A^N of an NxN max-plus matrix and tracks the maximum cycle
//   mean max(diag(A^k)[i] / k) as an exact fraction mean_num/mean_den.
//   Optional feature macro: MAXPLUS_CYCLE_MEAN_QUOT_EN adds a restoring
//   divider state that produces mean_quot = floor(mean_num/mean_den);
//   without it mean_quot is tied to 0.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     start        : request, accepted only while idle
//     a_in         : row-major matrix, element [i][j] at slice (i*N+j)
//     busy         : computation in progress
//     done         : one-cycle pulse when the result outputs update
//     cycle_found  : at least one cycle exists
//     mean_num     : best diagonal weight
//     mean_den     : best cycle length k
//     mean_quot    : floor(mean_num/mean_den) (feature build only)
// -----------------------------------------------------------------------------
module maxplus_cycle_mean
    import maxplus_pkg::*;
#(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = acc_width(N, DATA_WIDTH),
    parameter int K_WIDTH    = $clog2(N + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [N*N*DATA_WIDTH-1:0] a_in,
    output logic                      busy,
    output logic                      done,
    output logic                      cycle_found,
    output logic [ACC_WIDTH-1:0]      mean_num,
    output logic [K_WIDTH-1:0]        mean_den,
    output logic [ACC_WIDTH-1:0]      mean_quot
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CW    = ACC_WIDTH + K_WIDTH;

    localparam logic [DATA_WIDTH-1:0] DATA_EPS = DATA_WIDTH'(all_ones(DATA_WIDTH));
    localparam logic [ACC_WIDTH-1:0]  ACC_EPS  = ACC_WIDTH'(all_ones(ACC_WIDTH));
    localparam logic [IDX_W-1:0]      LAST     = IDX_W'(N - 1);
    localparam logic [K_WIDTH-1:0]    K_LAST   = K_WIDTH'(N);

    state_t state;

    logic [ACC_WIDTH-1:0] a_m  [N][N];
    logic [ACC_WIDTH-1:0] p_m  [N][N];
    logic [ACC_WIDTH-1:0] pn_m [N][N];

    logic [IDX_W-1:0]   ci, cj, cl;
    logic [K_WIDTH-1:0] ck;

    logic                 best_valid, best_valid_nx;
    logic [ACC_WIDTH-1:0] best_num,   best_num_nx;
    logic [K_WIDTH-1:0]   best_den,   best_den_nx;
    logic [CW-1:0]        cand_lhs,   cand_rhs;

    logic                 calc_step;
    logic [ACC_WIDTH-1:0] acc_next;

    assign calc_step = (state == CALC);

    maxplus_mac #(
        .W (ACC_WIDTH)
    ) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (calc_step),
        .clear    (cl == '0),
        .p_elem   (p_m[ci][cl]),
        .a_elem   (a_m[cl][cj]),
        .acc_next (acc_next)
    );

    // Diagonal candidate check. Ratios are compared by cross-multiplication;
    // strict '>' keeps the earliest (smallest k, then smallest i) on ties.
    always_comb begin
        best_valid_nx = best_valid;
        best_num_nx   = best_num;
        best_den_nx   = best_den;
        cand_lhs      = CW'(acc_next) * CW'(best_den);
        cand_rhs      = CW'(best_num) * CW'(ck);
        if (calc_step && cl == LAST && ci == cj && acc_next != ACC_EPS) begin
            if (!best_valid || cand_lhs > cand_rhs) begin
                best_valid_nx = 1'b1;
                best_num_nx   = acc_next;
                best_den_nx   = ck;
            end
        end
    end

    // Matrix storage carries no reset: it is fully rewritten on every accept.
    // On the very last term of a power the final element is bypassed straight
    // into P because Pnext only receives it at the same edge.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_m[r][c] <= (a_in[(r*N+c)*DATA_WIDTH +: DATA_WIDTH] == DATA_EPS)
                               ? ACC_EPS
                               : ACC_WIDTH'(a_in[(r*N+c)*DATA_WIDTH +: DATA_WIDTH]);
                    p_m[r][c] <= (r == c) ? '0 : ACC_EPS;
                end
            end
        end else if (calc_step && cl == LAST) begin
            pn_m[ci][cj] <= acc_next;
            if (ci == LAST && cj == LAST) begin
                for (int r = 0; r < N; r++) begin
                    for (int c = 0; c < N; c++) begin
                        p_m[r][c] <= pn_m[r][c];
                    end
                end
                p_m[LAST][LAST] <= acc_next;
            end
        end
    end

`ifdef MAXPLUS_CYCLE_MEAN_QUOT_EN
    localparam int DC_W = $clog2(ACC_WIDTH);

    logic [DC_W-1:0]      div_cnt;
    logic [K_WIDTH-1:0]   div_rem;
    logic [ACC_WIDTH-1:0] div_dvd;
    logic [ACC_WIDTH-1:0] div_quo;
    logic [K_WIDTH:0]     div_trial;
    logic                 div_take;

    // Remainder is always below the divisor, so K_WIDTH+1 bits suffice.
    assign div_trial = {div_rem, div_dvd[ACC_WIDTH-1]};
    assign div_take  = (div_trial >= {1'b0, best_den});
`else
    assign mean_quot = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            cycle_found <= 1'b0;
            mean_num    <= '0;
            mean_den    <= '0;
            ci          <= '0;
            cj          <= '0;
            cl          <= '0;
            ck          <= '0;
            best_valid  <= 1'b0;
            best_num    <= '0;
            best_den    <= '0;
`ifdef MAXPLUS_CYCLE_MEAN_QUOT_EN
            mean_quot   <= '0;
            div_cnt     <= '0;
            div_rem     <= '0;
            div_dvd     <= '0;
            div_quo     <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= CALC;
                        busy       <= 1'b1;
                        ci         <= '0;
                        cj         <= '0;
                        cl         <= '0;
                        ck         <= K_WIDTH'(1);
                        best_valid <= 1'b0;
                        best_num   <= '0;
                        best_den   <= '0;
                    end
                end
                CALC: begin
                    best_valid <= best_valid_nx;
                    best_num   <= best_num_nx;
                    best_den   <= best_den_nx;
                    // l innermost, then j, then i, then k
                    if (cl != LAST) begin
                        cl <= cl + 1'b1;
                    end else begin
                        cl <= '0;
                        if (cj != LAST) begin
                            cj <= cj + 1'b1;
                        end else begin
                            cj <= '0;
                            if (ci != LAST) begin
                                ci <= ci + 1'b1;
                            end else begin
                                ci <= '0;
                                ck <= ck + 1'b1;
                                if (ck == K_LAST) begin
`ifdef MAXPLUS_CYCLE_MEAN_QUOT_EN
                                    state   <= DIV;
                                    div_cnt <= '0;
                                    div_rem <= '0;
                                    div_dvd <= best_num_nx;
                                    div_quo <= '0;
`else
                                    state   <= DONE;
`endif
                                end
                            end
                        end
                    end
                end
`ifdef MAXPLUS_CYCLE_MEAN_QUOT_EN
                DIV: begin
                    div_rem <= div_take ? K_WIDTH'(div_trial - {1'b0, best_den})
                                        : div_trial[K_WIDTH-1:0];
                    div_dvd <= div_dvd << 1;
                    div_quo <= {div_quo[ACC_WIDTH-2:0], div_take};
                    div_cnt <= div_cnt + 1'b1;
                    if (div_cnt == DC_W'(ACC_WIDTH - 1)) begin
                        state <= DONE;
                    end
                end
`endif
                DONE: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    cycle_found <= best_valid;
                    mean_num    <= best_num;
                    mean_den    <= best_den;
`ifdef MAXPLUS_CYCLE_MEAN_QUOT_EN
                    mean_quot   <= best_valid ? div_quo : '0;
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/maxplus_cycle_mean.md
Name: maxplus_cycle_mean

Overview:
Parametrised max-plus (tropical) matrix engine. It computes the powers A^1..A^N of an N×N weighted adjacency matrix and, from them, the maximum cycle mean: the maximum over k and i of diag(A^k)[i]/k. It sits in the LMP path as the generalised, handshaked successor of the fixed 4×4 power/boundary block. The result is an exact fraction, and an optional quotient is available.

Parameters:
- N, 4, matrix dimension (2..8).
- DATA_WIDTH, 8, unsigned element width. The all-ones code is EPS (no edge).
- ACC_WIDTH, DATA_WIDTH+$clog2(N)+1, width of internal power elements. All-ones is EPS.
- K_WIDTH, $clog2(N+1), width of the cycle length k.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, reset: asynchronous, active-low.
- start, input, 1, request. Accepted only while busy=0.
- a_in, input, N*N*DATA_WIDTH, row-major; element [i][j] is at bits ((i*N+j)+1)*DATA_WIDTH-1 down to (i*N+j)*DATA_WIDTH, with [0][0] at the LSB. Sampled on the accept cycle.
- busy, output, 1, high from the cycle after accept until done.
- done, output, 1, one-cycle pulse when results update.
- cycle_found, output, 1, at least one cycle exists.
- mean_num, output, ACC_WIDTH, best diagonal weight.
- mean_den, output, K_WIDTH, best cycle length k.
- mean_quot, output, ACC_WIDTH, floor(mean_num/mean_den). Meaningful only with the optional feature.

Behaviour:
- Reset: busy=0, done=0, cycle_found=0, mean_num=0, mean_den=0, mean_quot=0. FSM goes to IDLE. Reset mid-operation aborts the computation with no done pulse.
- States: IDLE, CALC, DIV (optional), DONE.
  - IDLE→CALC on start: latch a_in into A; set P = max-plus identity (diag 0, else EPS); k=1; i=j=l=0; clear the best-so-far.
  - CALC: one step per cycle, with the l loop innermost, then j, then i, then k. Step: acc = (l==0 ? EPS : acc) ⊕max (P[i][l] ⊗ A[l][j]).
    - ⊗ is saturating-free addition. If either operand is EPS, the product is EPS.
    - ⊕max treats EPS as −∞.
    - At l=N-1, write acc into Pnext[i][j].
    - At i=j=l=N-1, copy P<=Pnext (with the final element bypassed in) and k<=k+1.
  - CALC lasts exactly N^4 cycles.
- Diagonal update: when l=N-1, i==j and the element is not EPS, candidate = (v, k). It replaces the best if no best exists or v*best_den > best_num*k (cross-multiplication, no division). Strict >, so on equal ratios the smallest k, then the smallest i, wins.
- CALC→DONE (or →DIV). DONE asserts done for one cycle, registers cycle_found/mean_num/mean_den(/mean_quot), then returns to IDLE.
- Latency: done is high exactly N^4+1 cycles after the accept cycle (N=4: 257) without the feature.
- No cycle: cycle_found=0, mean_num=0, mean_den=0, mean_quot=0.
- Outputs hold their previous results while busy. start while busy is ignored. start in the same cycle as DONE is ignored; it is accepted from IDLE on the next cycle.
- Widths: the maximum non-EPS value is N*(2^DATA_WIDTH-2), which fits in ACC_WIDTH below EPS. Input EPS maps to ACC EPS; other values are zero-extended. The cross-product uses an ACC_WIDTH+K_WIDTH internal width.

Optional Feature:
- Macro: MAXPLUS_CYCLE_MEAN_QUOT_EN.
- Defined: adds a DIV state with a restoring divider of ACC_WIDTH iterations. done is high N^4+ACC_WIDTH+1 cycles after accept. mean_quot = floor(mean_num/mean_den), and 0 when no cycle exists.
- Undefined: no DIV state, mean_quot is tied to 0, and latency is N^4+1.

Decomposition:
- Package maxplus_pkg:
  - EPS constant helpers: the all-ones function for a given width.
  - ACC_WIDTH derivation function.
  - FSM state typedef (IDLE, CALC, DIV, DONE).
  - Functions mp_mul (EPS-aware add) and mp_max (EPS-as-−∞ max).
- One sub-module, maxplus_mac: the registered accumulate step (clear on l==0, mp_max of mp_mul), reused per element.
- The divider stays inline under the macro.

Test Plan:
- N=4, A[0][0]=5, all others EPS → after 257 cycles: done=1, cycle_found=1, mean_num=5, mean_den=1 (quot 5 with the feature).
- A[0][1]=3, A[1][0]=4, others EPS → num=7, den=2, quot=3.
- All EPS → cycle_found=0, num=0, den=0, quot=0, with done still at 257.
- Tie: A[0][0]=2, A[1][2]=1, A[2][1]=3, others EPS → num=2, den=1 (smallest k wins).
- All elements 254 (DATA_WIDTH=8) → num=254, den=1. Internal A^4 diagonal = 1016 with no wrap (ACC_WIDTH=11).
- Robustness:
  - start pulsed at cycles 10 and 100 after accept → ignored, single done.
  - rst_n low at cycle 120 → busy=0, no done, all outputs 0.
  - A new start afterwards completes normally.
